uart_tx_serial: RTL and testbench

UART_TX_SERIAL -- requirements
Module: uart_tx_serial

---
 rtl/uart_tx_serial.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_serial.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serial.sv
// 8N1 UART transmitter, CLK_DIV clocks per bit, LSB first.
// Define UART_TX_FIFO_EN for a 4-entry input FIFO; otherwise a single holding register is used.
module uart_tx_serial #(
  parameter int CLK_DIV = 207
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       txd,
  output logic       busy
);
  // state | meaning
  // IDLE  | line idle (1), waiting for a byte
  // START | start bit (0)
  // DATA  | data bits, LSB first
  // STOP  | stop bit (1)
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        baud_end;
  logic        ready_int;
  logic        push;
  logic        pop;
  logic        avail;
  logic [7:0]  head_byte;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign push     = in_valid & ready_int;
  assign pop      = avail & ((state == IDLE) | ((state == STOP) & baud_end));
  // Flops are held in reset while resetn=0, so only the port needs the gating.
  assign in_ready = ready_int & resetn;

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  assign ready_int = (count != 3'd4);
  assign avail     = (count != 3'd0);
  assign head_byte = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_byte;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic       hold_valid;
  logic [7:0] hold_byte;

  assign ready_int = (state == IDLE) & ~hold_valid;
  assign avail     = hold_valid;
  assign head_byte = hold_byte;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_byte  <= 8'h00;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_byte  <= in_byte;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= 16'd0;
          if (avail) begin
            state <= START;
            shreg <= head_byte;
            txd   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            state    <= DATA;
            txd      <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            // Chain straight into the next start bit when a byte is waiting.
            if (avail) begin
              state <= START;
              shreg <= head_byte;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serial.sv
// Directed bench for uart_tx_serial: table of single frames plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_serial;
  localparam int CLK_DIV = 207;
  localparam int BUDGET  = 30 * CLK_DIV;

  logic       clk;
  logic       resetn;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       txd;
  logic       busy;

  int checks;
  int failures;

  uart_tx_serial #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .txd      (txd),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] hold;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Handshakes one byte, then checks txd is still 1 after the acceptance edge and 0 after the next.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] hold, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready"}, {31'd0, in_ready}, 32'd1);
    in_byte  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_byte  = hold;
    @(negedge clk);
    check({name, " txd after accept"}, {31'd0, txd}, 32'd1);
    @(negedge clk);
    check({name, " start latency"}, {31'd0, txd}, 32'd0);
  endtask

  // Entered at the first negedge of the start bit; leaves at the last negedge of the stop bit.
  task automatic check_frame(input logic [9:0] exp, input string name);
    int bad;
    int busy_bad;
    busy_bad = 0;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < CLK_DIV; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (txd !== exp[b]) bad++;
        if (busy !== 1'b1) busy_bad++;
      end
      check($sformatf("%s line bit %0d bad cycles", name, b), bad, 0);
    end
    check({name, " busy during frame"}, busy_bad, 0);
  endtask

  task automatic wait_low(input string name);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({name, " start seen"}, {31'd0, txd}, 32'd0);
  endtask

  task automatic measure_gap(output int gap);
    gap = 0;
    @(negedge clk);
    while (txd !== 1'b0 && gap < BUDGET) begin
      gap++;
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, " idle txd"}, {31'd0, txd}, 32'd1);
    check({name, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic quiet_after_reset(input string name);
    int bad;
    bad = 0;
    for (int c = 0; c < 12 * CLK_DIV; c++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check({name, " no frame remnant"}, bad, 0);
  endtask

  task automatic reset_mid(input int bitn, input logic exp_bit, input string name);
    send_byte(8'h0F, 8'h0F, name);
    repeat ((1 + bitn) * CLK_DIV + CLK_DIV / 2) @(negedge clk);
    check({name, " data bit before reset"}, {31'd0, txd}, {31'd0, exp_bit});
    #2;
    resetn = 1'b0;
    #1;
    check({name, " txd in reset"}, {31'd0, txd}, 32'd1);
    check({name, " busy in reset"}, {31'd0, busy}, 32'd0);
    check({name, " ready in reset"}, {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check({name, " ready after release"}, {31'd0, in_ready}, 32'd1);
    quiet_after_reset(name);
  endtask

  // Holds in_valid across a list of bytes while a monitor decodes the frames.
  task automatic stream(input logic [7:0] bytes[], input logic [9:0] frames[], input int n,
                        input bit fifo_mode, input string name);
    int ready_low;
    int gap;
    ready_low = 0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          int w;
          bit got;
          in_byte  = bytes[k];
          in_valid = 1'b1;
          w   = 0;
          got = 0;
          while (!got && w < BUDGET) begin
            @(negedge clk);
            if (in_ready) got = 1;
            else ready_low++;
            w++;
          end
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        wait_low(name);
        for (int k = 0; k < n; k++) begin
          check_frame(frames[k], $sformatf("%s frame %0d", name, k));
          if (k < n - 1) begin
            measure_gap(gap);
            if (fifo_mode) check($sformatf("%s gap %0d", name, k), gap, 0);
            else check($sformatf("%s gap %0d at least 1", name, k), {31'd0, gap >= 1}, 32'd1);
          end
        end
      end
    join
    if (fifo_mode) check({name, " ready dropped when full"}, {31'd0, ready_low > 0}, 32'd1);
    else check({name, " ready low across frames"}, {31'd0, ready_low >= 20 * CLK_DIV}, 32'd1);
    check_idle(name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bytes[];
    logic [9:0] frames[];

    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    vecs[0] = '{data: 8'h55, hold: 8'h55, frame: 10'h2AA};
    vecs[1] = '{data: 8'h00, hold: 8'hFF, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, hold: 8'h00, frame: 10'h3FE};
    vecs[3] = '{data: 8'hA1, hold: 8'h5E, frame: 10'h342};

    repeat (3) @(negedge clk);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset ready", {31'd0, in_ready}, 32'd0);
    resetn = 1'b1;
    #1;
    check("ready first edge", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].data, vecs[i].hold, $sformatf("vec%0d", i));
      check_frame(vecs[i].frame, $sformatf("vec%0d", i));
      check_idle($sformatf("vec%0d", i));
    end

`ifdef UART_TX_FIFO_EN
    bytes  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    frames = '{10'h202, 10'h204, 10'h206, 10'h208, 10'h20A, 10'h20C};
    stream(bytes, frames, 6, 1'b1, "fifo6");
`else
    bytes  = '{8'hA1, 8'hB2, 8'hC3};
    frames = '{10'h342, 10'h364, 10'h386};
    stream(bytes, frames, 3, 1'b0, "hold3");
`endif

    reset_mid(5, 1'b0, "rst_bit5");
    reset_mid(3, 1'b1, "rst_bit3");
    send_byte(8'h3C, 8'h3C, "post_rst");
    check_frame(10'h278, "post_rst");
    check_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
